// File: rtl/if_id_stage.sv
// Instruction-fetch front end and IF/ID pipeline register for the 5-stage RV32 core.
// Owns the PC, drives the same-cycle instruction-memory handshake, applies ID branch
// redirects and hazard-unit stalls, and presents the latched instruction to ID.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] ins_o,
   output logic        valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] bubble_cnt_o
`endif
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_ins_q, id_ins_d;
   logic        id_valid_q, id_valid_d;
   logic        fetch_done;
   logic        load_fetch;
   logic        load_bubble;

   assign imem_req_o  = (state_q == StRun) && !stall_i;
   assign imem_addr_o = pc_q;
   assign fetch_done  = imem_req_o && imem_ready_i;

   assign pc_o    = id_pc_q;
   assign ins_o   = id_ins_q;
   assign valid_o = id_valid_q;

   // Next-state: stall beats branch beats fetch; anything else loads a bubble.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_pc_d     = id_pc_q;
      id_ins_d    = id_ins_q;
      id_valid_d  = id_valid_q;
      load_fetch  = 1'b0;
      load_bubble = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (stall_i) begin
               // Hold everything; ID re-presents any branch once the stall clears.
            end else if (branch_i) begin
               pc_d        = {branch_target_i[31:2], 2'b00};
               id_pc_d     = 32'h0;
               id_ins_d    = NOP_INS;
               id_valid_d  = 1'b0;
               load_bubble = 1'b1;
            end else if (fetch_done) begin
               id_pc_d    = pc_q;
               id_ins_d   = imem_data_i;
               id_valid_d = 1'b1;
               pc_d       = pc_q + 32'd4;
               load_fetch = 1'b1;
            end else begin
               id_pc_d     = 32'h0;
               id_ins_d    = NOP_INS;
               id_valid_d  = 1'b0;
               load_bubble = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, PC and IF/ID register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         id_pc_q    <= 32'h0;
         id_ins_q   <= NOP_INS;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_ins_q   <= id_ins_d;
         id_valid_q <= id_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   // Performance counters; both wrap naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else begin
         if (load_fetch) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (load_bubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt = load_fetch ^ load_bubble;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: table of per-cycle vectors plus hand-written
// reset and PC-wrap sequences. Honours FETCH_PERF_CNT_EN when defined.
module tb_if_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] target = 32'h0;
   logic        ready = 1'b0;
   logic        req;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] pc;
   logic [31:0] ins;
   logic        valid;

   // Second instance exercising the PC wrap from RESET_PC=FFFF_FFFC.
   logic        req_w;
   logic [31:0] addr_w;
   logic [31:0] data_w;
   logic [31:0] pc_w;
   logic [31:0] ins_w;
   logic        valid_w;

   int checks = 0;
   int errors = 0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt, bcnt, fcnt_w, bcnt_w;
   logic [31:0] bcnt_snap;
`endif

   always #5 clk = ~clk;

   // Memory: word at address A is 32'h0010_0093 + A, same-cycle response.
   assign data   = 32'h0010_0093 + addr;
   assign data_w = 32'h0010_0093 + addr_w;

   if_id_stage dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .stall_i        (stall),
      .branch_i       (branch),
      .branch_target_i(target),
      .imem_req_o     (req),
      .imem_addr_o    (addr),
      .imem_ready_i   (ready),
      .imem_data_i    (data),
      .pc_o           (pc),
      .ins_o          (ins),
      .valid_o        (valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o    (fcnt),
      .bubble_cnt_o   (bcnt)
`endif
   );

   if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .stall_i        (1'b0),
      .branch_i       (1'b0),
      .branch_target_i(32'h0),
      .imem_req_o     (req_w),
      .imem_addr_o    (addr_w),
      .imem_ready_i   (1'b1),
      .imem_data_i    (data_w),
      .pc_o           (pc_w),
      .ins_o          (ins_w),
      .valid_o        (valid_w)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o    (fcnt_w),
      .bubble_cnt_o   (bcnt_w)
`endif
   );

   typedef struct {
      logic        stall;
      logic        branch;
      logic [31:0] target;
      logic        ready;
      logic        exp_req;    // before the edge
      logic        exp_valid;  // after the edge
      logic [31:0] exp_pc;
      logic [31:0] exp_ins;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs [18];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h0010_0093 + a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                               input logic r, input logic eq, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei,
                               input logic [31:0] ea);
      vec_t v;
      v.stall = s; v.branch = b; v.target = t; v.ready = r; v.exp_req = eq;
      v.exp_valid = ev; v.exp_pc = ep; v.exp_ins = ei; v.exp_addr = ea;
      return v;
   endfunction

   initial begin
      // stall br  target        rdy req val pc       ins          addr
      vecs[0]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h00, mem(32'h00), 32'h04);
      vecs[1]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h04, mem(32'h04), 32'h08);
      vecs[2]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h08, mem(32'h08), 32'h0C);
      vecs[3]  = mk(1, 0, 32'h0,  1, 0, 1, 32'h08, mem(32'h08), 32'h0C);
      vecs[4]  = mk(1, 0, 32'h0,  1, 0, 1, 32'h08, mem(32'h08), 32'h0C);
      vecs[5]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h0C, mem(32'h0C), 32'h10);
      vecs[6]  = mk(0, 1, 32'h40, 1, 1, 0, 32'h00, NOP,         32'h40);
      vecs[7]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h40, mem(32'h40), 32'h44);
      vecs[8]  = mk(0, 1, 32'h43, 1, 1, 0, 32'h00, NOP,         32'h40);
      vecs[9]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h40, mem(32'h40), 32'h44);
      vecs[10] = mk(1, 1, 32'h80, 1, 0, 1, 32'h40, mem(32'h40), 32'h44);
      vecs[11] = mk(0, 1, 32'h80, 1, 1, 0, 32'h00, NOP,         32'h80);
      vecs[12] = mk(0, 0, 32'h0,  1, 1, 1, 32'h80, mem(32'h80), 32'h84);
      vecs[13] = mk(0, 1, 32'h20, 1, 1, 0, 32'h00, NOP,         32'h20);
      vecs[14] = mk(0, 0, 32'h0,  0, 1, 0, 32'h00, NOP,         32'h20);
      vecs[15] = mk(0, 0, 32'h0,  0, 1, 0, 32'h00, NOP,         32'h20);
      vecs[16] = mk(0, 0, 32'h0,  0, 1, 0, 32'h00, NOP,         32'h20);
      vecs[17] = mk(0, 0, 32'h0,  1, 1, 1, 32'h20, mem(32'h20), 32'h24);

      // Reset, with ready high to show IDLE issues no request.
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", {31'h0, valid}, 32'h0);
      chk("reset pc_o", pc, 32'h0);
      chk("reset ins_o", ins, NOP);
      chk("reset req", {31'h0, req}, 32'h0);
      chk("reset addr", addr, 32'h0);
      chk("wrap reset addr", addr_w, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
      chk("reset fetch_cnt", fcnt, 32'h0);
      chk("reset bubble_cnt", bcnt, 32'h0);
`endif

      // Release reset; idle cycle with stall/branch asserted must be ignored.
      @(negedge clk);
      rst = 1'b1; branch = 1'b1; target = 32'h100;
      @(posedge clk); #1;
      chk("idle no req", {31'h0, req}, 32'h0);
      chk("idle addr held", addr, 32'h0);
      chk("idle valid", {31'h0, valid}, 32'h0);

      // One-cycle start pulse.
      @(negedge clk);
      branch = 1'b0; target = 32'h0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start addr", addr, 32'h0);
      chk("start valid", {31'h0, valid}, 32'h0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         stall = vecs[i].stall; branch = vecs[i].branch;
         target = vecs[i].target; ready = vecs[i].ready;
`ifdef FETCH_PERF_CNT_EN
         if (i == 14) bcnt_snap = bcnt;
`endif
         #1;
         chk($sformatf("v%0d req", i), {31'h0, req}, {31'h0, vecs[i].exp_req});
         @(posedge clk); #1;
         chk($sformatf("v%0d valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
         chk($sformatf("v%0d pc_o", i), pc, vecs[i].exp_pc);
         chk($sformatf("v%0d ins_o", i), ins, vecs[i].exp_ins);
         chk($sformatf("v%0d addr", i), addr, vecs[i].exp_addr);
         if (i == 0) begin
            chk("wrap first pc_o", pc_w, 32'hFFFF_FFFC);
            chk("wrap first ins_o", ins_w, 32'h0010_008F);
            chk("wrap second addr", addr_w, 32'h0);
         end
`ifdef FETCH_PERF_CNT_EN
         if (i == 16) chk("bubble_cnt +3", bcnt - bcnt_snap, 32'd3);
`endif
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt total", fcnt, 32'd8);
      chk("bubble_cnt total", bcnt, 32'd7);
`endif

      // Mid-run reset.
      @(negedge clk);
      stall = 1'b0; branch = 1'b0; ready = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst valid", {31'h0, valid}, 32'h0);
      chk("midrst req", {31'h0, req}, 32'h0);
      chk("midrst ins_o", ins, NOP);
      chk("midrst pc_o", pc, 32'h0);
      chk("midrst addr", addr, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst stays idle", {31'h0, req}, 32'h0);

      // Restart and confirm fetching begins again at RESET_PC.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart req", {31'h0, req}, 32'h1);
      @(posedge clk); #1;
      chk("restart pc_o", pc, 32'h0);
      chk("restart ins_o", ins, mem(32'h0));
      chk("restart valid", {31'h0, valid}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
